// File: rtl/window_3x3_if.sv
// Pixel-stream and window-output bundle for the 3x3 neighbourhood builder.
// The pixel source drives through master; window_3x3 connects through slave.
interface window_3x3_if #(
    parameter int PIXEL_WIDTH = 3
);
    logic                       enable;
    logic                       sof;
    logic [PIXEL_WIDTH-1:0]     data_in;
    logic [15:0]                line_width;
    logic [9*PIXEL_WIDTH-1:0]   window;
    logic                       out_valid;
    logic [15:0]                center_row;
    logic [15:0]                center_col;

    modport master (
        output enable, sof, data_in, line_width,
        input  window, out_valid, center_row, center_col
    );

    modport slave (
        input  enable, sof, data_in, line_width,
        output window, out_valid, center_row, center_col
    );
endinterface

// File: rtl/window_3x3.sv
// Assembles a registered 3x3 neighbourhood from a raster pixel stream using
// two line memories (previous two rows) and a three-column shift register.
module window_3x3 #(
    parameter int PIXEL_WIDTH  = 3,
    parameter int ADDRESS_SIZE = 12
) (
    input  logic        clk,
    input  logic        reset,
    window_3x3_if.slave pix
);
    localparam int DEPTH = 1 << ADDRESS_SIZE;
    localparam int LW_W  = ADDRESS_SIZE + 1;
    localparam logic [LW_W-1:0] MAX_LW  = LW_W'(DEPTH);
    localparam logic [31:0]     DEPTH_U = 32'(DEPTH);

    logic [PIXEL_WIDTH-1:0]  r_mem0 [DEPTH];
    logic [PIXEL_WIDTH-1:0]  r_mem1 [DEPTH];
    logic [PIXEL_WIDTH-1:0]  r_rd0;
    logic [PIXEL_WIDTH-1:0]  r_rd1;

    logic [LW_W-1:0]         r_lw;
    logic [LW_W-1:0]         w_lwSof;
    logic [LW_W-1:0]         w_lwCur;
    logic [ADDRESS_SIZE-1:0] r_col;
    logic [ADDRESS_SIZE-1:0] w_curCol;
    logic [ADDRESS_SIZE-1:0] w_nextCol;
    logic [15:0]             r_row;
    logic [15:0]             w_curRow;
    logic [15:0]             w_nextRow;
    logic                    w_lastCol;

    logic                    r_s0Valid;
    logic [PIXEL_WIDTH-1:0]  r_s0Bot;
    logic [15:0]             r_s0Row;
    logic [ADDRESS_SIZE-1:0] r_s0Col;
    logic                    r_s0LwOk;

    logic                    r_s1Valid;
    logic [PIXEL_WIDTH-1:0]  r_s1Top;
    logic [PIXEL_WIDTH-1:0]  r_s1Mid;
    logic [PIXEL_WIDTH-1:0]  r_s1Bot;
    logic [15:0]             r_s1Row;
    logic [ADDRESS_SIZE-1:0] r_s1Col;
    logic                    r_s1LwOk;

    logic [PIXEL_WIDTH-1:0]  r_win [3][3];
    logic                    r_outValid;
    logic [15:0]             r_centerRow;
    logic [15:0]             r_centerCol;
    logic [9*PIXEL_WIDTH-1:0] w_window;

    // An accepted sof pixel is (0,0) and uses the freshly clamped width immediately.
    always_comb begin
        w_lwSof = MAX_LW;
        if (pix.line_width == 16'd0) begin
            w_lwSof = LW_W'(1);
        end else if (32'(pix.line_width) < DEPTH_U) begin
            w_lwSof = LW_W'(pix.line_width);
        end
        w_curCol  = pix.sof ? '0 : r_col;
        w_curRow  = pix.sof ? '0 : r_row;
        w_lwCur   = pix.sof ? w_lwSof : r_lw;
        w_lastCol = ({1'b0, w_curCol} == (w_lwCur - LW_W'(1)));
        w_nextCol = w_lastCol ? '0 : w_curCol + ADDRESS_SIZE'(1);
        w_nextRow = w_curRow;
        if (w_lastCol && (w_curRow != 16'hFFFF)) begin
            w_nextRow = w_curRow + 16'd1;
        end
    end

    // Read-first line memories: M1 takes over the row M0 is about to lose.
    always_ff @(posedge clk) begin
        if (pix.enable && !reset) begin
            r_rd0            <= r_mem0[w_curCol];
            r_rd1            <= r_mem1[w_curCol];
            r_mem0[w_curCol] <= pix.data_in;
            r_mem1[w_curCol] <= r_mem0[w_curCol];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lw      <= MAX_LW;
            r_row     <= '0;
            r_col     <= '0;
            r_s0Valid <= 1'b0;
            r_s0Bot   <= '0;
            r_s0Row   <= '0;
            r_s0Col   <= '0;
            r_s0LwOk  <= 1'b0;
        end else begin
            r_s0Valid <= pix.enable;
            if (pix.enable) begin
                r_lw     <= w_lwCur;
                r_row    <= w_nextRow;
                r_col    <= w_nextCol;
                r_s0Bot  <= pix.data_in;
                r_s0Row  <= w_curRow;
                r_s0Col  <= w_curCol;
                r_s0LwOk <= (w_lwCur >= LW_W'(3));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1Valid <= 1'b0;
            r_s1Top   <= '0;
            r_s1Mid   <= '0;
            r_s1Bot   <= '0;
            r_s1Row   <= '0;
            r_s1Col   <= '0;
            r_s1LwOk  <= 1'b0;
        end else begin
            r_s1Valid <= r_s0Valid;
            if (r_s0Valid) begin
                r_s1Top  <= r_rd1;
                r_s1Mid  <= r_rd0;
                r_s1Bot  <= r_s0Bot;
                r_s1Row  <= r_s0Row;
                r_s1Col  <= r_s0Col;
                r_s1LwOk <= r_s0LwOk;
            end
        end
    end

    // Window shifts only on real pixels; border positions shift but stay unflagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outValid  <= 1'b0;
            r_centerRow <= '0;
            r_centerCol <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else begin
            r_outValid <= 1'b0;
            if (r_s1Valid) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= r_s1Top;
                r_win[1][2] <= r_s1Mid;
                r_win[2][2] <= r_s1Bot;
                r_outValid  <= (r_s1Row >= 16'd2) && (r_s1Col >= ADDRESS_SIZE'(2)) && r_s1LwOk;
                r_centerRow <= r_s1Row - 16'd1;
                r_centerCol <= 16'(r_s1Col) - 16'd1;
            end
        end
    end

    always_comb begin
        w_window = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_window[(3*r+c)*PIXEL_WIDTH +: PIXEL_WIDTH] = r_win[r][c];
            end
        end
    end

    assign pix.window     = w_window;
    assign pix.out_valid  = r_outValid;
    assign pix.center_row = r_centerRow;
    assign pix.center_col = r_centerCol;
endmodule

// File: doc/window_3x3.md
# window_3x3

Builds a 3x3 pixel neighbourhood from a raster pixel stream for the image-processing chain, e.g. morphology or edge filters after colour thresholding. Two internal line memories hold the previous two rows at a programmable line width. A column shift register assembles each window. One registered window is emitted per accepted pixel once the window lies fully inside the frame.

## Interface
- PIXEL_WIDTH, 3: bits per pixel (W).
- ADDRESS_SIZE, 12: line-memory address bits; maximum line width 2^ADDRESS_SIZE.
- clk  in  1: clock, all logic on rising edge.
- reset  in  1: synchronous, active-high reset.
- enable  in  1: pixel valid; data_in accepted on any cycle with enable=1.
- sof  in  1: start of frame; qualifies the accepted pixel as row 0, col 0; ignored when enable=0.
- data_in  in  W: pixel value.
- line_width  in  16: pixels per line; sampled only on an accepted sof pixel.
- window  out  9*W: window[(3*r+c)*W +: W]; r=0 top/oldest row; c=0 left/oldest column; centre at r=1, c=1.
- out_valid  out  1: one-cycle pulse, window holds a complete interior neighbourhood.
- center_row  out  16: row index of the window centre.
- center_col  out  16: column index of the window centre.

## Operation
- Position counters:
  - col counts 0..lw-1 per accepted pixel, then wraps to 0 and increments row.
  - row saturates at 16'hFFFF.
  - An accepted sof forces this pixel to (0,0) and loads lw.
- lw rules:
  - lw = line_width clamped to [1, 2^ADDRESS_SIZE].
  - lw < 3 means out_valid is never asserted.
  - lw holds 2^ADDRESS_SIZE after reset until the first sof.
- Line memories M0 and M1:
  - Each has 2^ADDRESS_SIZE x W entries, addressed by col.
  - On an accepted pixel at col c, read M0[c] (row-1) and M1[c] (row-2).
  - Then write M0[c] <= data_in and M1[c] <= old M0[c].
  - Read-before-write at the same address, same cycle.
- Stage 1 (cycle t+1):
  - Register the read column {M1[c], M0[c], data_in}, (row, col) and a valid bit.
- Stage 2 (cycle t+2), only when stage-1 valid:
  - Shift window columns left: c0 <= c1, c1 <= c2, c2 <= new column; top=M1, mid=M0, bottom=data_in.
  - out_valid <= (row >= 2) && (col >= 2) && (lw >= 3).
  - center_row <= row-1; center_col <= col-1.
- When stage-1 valid is low, window and center_* hold and out_valid=0.
- Memory contents are never cleared. Rows 0–1 and cols 0–1 are gated by out_valid, so stale data is never flagged valid.
- sof mid-line or mid-frame: counters restart at (0,0) on the sof pixel. The in-flight pipeline completes normally. The next out_valid requires row >= 2 and col >= 2 of the new frame.
- Count per frame of R rows: exactly (R-2)*(lw-2) out_valid pulses.

## Timing
- Latency: pixel accepted at rising edge t gives out_valid/window at edge t+2, i.e. visible in cycle t+2.
- Full throughput: enable may stay high every cycle with no stalls. Gaps in enable produce gaps in out_valid.
- Reset effects:
  - window = 0, out_valid = 0, center_row = 0, center_col = 0.
  - Pipeline valid bits are cleared; row = 0, col = 0.
  - lw = 2^ADDRESS_SIZE.
- Reset asserted mid-frame:
  - out_valid is 0 from the cycle after reset is sampled.
  - Pixels accepted while reset = 1 are discarded.
  - Before sof, data restarts at (0,0) after reset.
- line_width changes without sof have no effect.

## Test plan
- Basic window:
  - Stimulus: lw=5, 4 rows, W=3, pixel=(5*row+col) mod 8, enable continuous, sof on first pixel.
  - First out_valid at 2 cycles after pixel (2,2). Rows top→bottom 0,1,2 / 5,6,7 / 2,3,4. center=(1,1).
  - 6 pulses total.
- Gapped input: same frame with enable toggling 1,0,1,0.
  - Identical window values and pulse count.
  - Each pulse exactly 2 cycles after its triggering pixel.
- Wrap and line edge: lw=5.
  - No out_valid for cols 0–1 of any row.
  - After col 4 the next pixel is (row+1, 0).
- Small width: lw=2, 5 rows. Zero out_valid. lw=3, 3 rows: exactly 1 pulse, center=(1,1).
- Mid-frame sof: sof asserted at (2,3) of frame A with lw=6. No out_valid until new (2,2). Counters restart; window rows come from the new frame only.
- Reset mid-frame:
  - Assert reset for 1 cycle during row 3. All outputs are 0 next cycle.
  - With no sof, the next pixel is treated as (0,0). The first pulse follows 2 rows + 2 pixels later.
